dmem_arbiter: RTL and testbench

Single-port arbiter and sequencer for the data cache (`dcache`) that shares its one read/write port between the CPU load/store unit and a DMA/loader requester. Sits between `cpu` and `dcache` in the top level. It accepts one request per cycle under valid/ready handshakes, drives the cache one cycle later and returns a response one cycle after that. A bounded-burst fairness counter prevents the CPU from starving the DMA port.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arb_grant.sv | 39 +++
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the dcache port arbiter.
package dmem_arb_pkg;

    localparam int DMEM_WIDTH        = 32;
    localparam int DMEM_ADDR_W       = 6;
    localparam int DEF_MAX_CPU_BURST = 4;

    // Who owns the access currently travelling down the pipe
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    // One dcache command; widths track the arbiter's default WIDTH/ADDR_W
    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_WIDTH-1:0]  wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arb_grant.sv
// Grant decision between CPU and DMA with a bounded CPU burst counter so
// a continuously busy CPU cannot starve the DMA requester.
import dmem_arb_pkg::*;

module dmem_arb_grant #(
    parameter int MAX_CPU_BURST = DEF_MAX_CPU_BURST
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_valid,
    input  logic dma_valid,
    output logic cpu_grant,
    output logic dma_grant
);

    localparam logic [3:0] MAX_B = 4'(MAX_CPU_BURST);

    logic [3:0] burst_cnt;
    logic       at_limit;

    assign at_limit = (burst_cnt == MAX_B);

    // CPU has priority until it has used up its burst while DMA waits
    always_comb begin
        cpu_grant = cpu_valid & (~dma_valid | ~at_limit);
        dma_grant = dma_valid & ~cpu_grant;
    end

    // Count consecutive CPU wins only while DMA is actually waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            burst_cnt <= '0;
        else if (~dma_valid | dma_grant)
            burst_cnt <= '0;
        else if (cpu_grant && !at_limit)
            burst_cnt <= burst_cnt + 4'd1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dcache arbiter: ARB (grant) -> ACC (drive dcache, sample
// rdata) -> RSP (registered response to the owning requester).
// Optional per-requester stall counters: define DMEM_ARB_STALL_CNT_EN.
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter int WIDTH         = DMEM_WIDTH,
    parameter int ADDR_W        = DMEM_ADDR_W,
    parameter int MAX_CPU_BURST = DEF_MAX_CPU_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [WIDTH-1:0]  cpu_req_wdata,
    output logic              cpu_resp_valid,
    output logic [WIDTH-1:0]  cpu_resp_rdata,
    input  logic              dma_req_valid,
    output logic              dma_req_ready,
    input  logic              dma_req_we,
    input  logic [ADDR_W-1:0] dma_req_addr,
    input  logic [WIDTH-1:0]  dma_req_wdata,
    output logic              dma_resp_valid,
    output logic [WIDTH-1:0]  dma_resp_rdata,
    output logic              dmem_w_en,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [WIDTH-1:0]  dmem_wdata,
`ifdef DMEM_ARB_STALL_CNT_EN
    output logic [15:0]       cpu_stall_cnt,
    output logic [15:0]       dma_stall_cnt,
`endif
    input  logic [WIDTH-1:0]  dmem_rdata
);

    logic      cpu_grant, dma_grant;
    logic      acc_vld;
    owner_e    acc_own;
    dmem_req_t acc_req;

    dmem_arb_grant #(.MAX_CPU_BURST(MAX_CPU_BURST)) u_grant (
        .clk       (clk),
        .reset     (reset),
        .cpu_valid (cpu_req_valid),
        .dma_valid (dma_req_valid),
        .cpu_grant (cpu_grant),
        .dma_grant (dma_grant)
    );

    // Responses cannot stall, so ready is purely the grant (masked in reset)
    always_comb begin
        cpu_req_ready = cpu_grant & ~reset;
        dma_req_ready = dma_grant & ~reset;
    end

    // ACC stage register: capture the granted command, or a zeroed bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_vld <= 1'b0;
            acc_own <= OWN_NONE;
            acc_req <= '0;
        end else begin
            acc_vld <= cpu_grant | dma_grant;
            if (cpu_grant) begin
                acc_own <= OWN_CPU;
                acc_req <= '{we: cpu_req_we, addr: cpu_req_addr, wdata: cpu_req_wdata};
            end else if (dma_grant) begin
                acc_own <= OWN_DMA;
                acc_req <= '{we: dma_req_we, addr: dma_req_addr, wdata: dma_req_wdata};
            end else begin
                acc_own <= OWN_NONE;
                acc_req <= '0;
            end
        end
    end

    // dcache drive; zero whenever the ACC slot is empty
    always_comb begin
        dmem_w_en  = acc_vld & acc_req.we;
        dmem_addr  = acc_vld ? acc_req.addr  : '0;
        dmem_wdata = acc_vld ? acc_req.wdata : '0;
    end

    // RSP stage: steer the sampled read data to the owner; stores return 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_resp_valid <= 1'b0;
            cpu_resp_rdata <= '0;
            dma_resp_valid <= 1'b0;
            dma_resp_rdata <= '0;
        end else begin
            cpu_resp_valid <= acc_vld && (acc_own == OWN_CPU);
            dma_resp_valid <= acc_vld && (acc_own == OWN_DMA);
            cpu_resp_rdata <= (acc_vld && acc_own == OWN_CPU && !acc_req.we) ? dmem_rdata : '0;
            dma_resp_rdata <= (acc_vld && acc_own == OWN_DMA && !acc_req.we) ? dmem_rdata : '0;
        end
    end

`ifdef DMEM_ARB_STALL_CNT_EN
    // Saturating count of cycles each requester waited (valid without ready)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_stall_cnt <= '0;
            dma_stall_cnt <= '0;
        end else begin
            if (cpu_req_valid && !cpu_req_ready && cpu_stall_cnt != 16'hFFFF)
                cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
            if (dma_req_valid && !dma_req_ready && dma_stall_cnt != 16'hFFFF)
                dma_stall_cnt <= dma_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural dcache.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req_valid = 1'b0, cpu_req_we = 1'b0;
    logic [5:0]  cpu_req_addr = '0;
    logic [31:0] cpu_req_wdata = '0;
    logic        dma_req_valid = 1'b0, dma_req_we = 1'b0;
    logic [5:0]  dma_req_addr = '0;
    logic [31:0] dma_req_wdata = '0;
    logic        cpu_req_ready, cpu_resp_valid, dma_req_ready, dma_resp_valid;
    logic [31:0] cpu_resp_rdata, dma_resp_rdata;
    logic        dmem_w_en;
    logic [5:0]  dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
`ifdef DMEM_ARB_STALL_CNT_EN
    logic [15:0] cpu_stall_cnt, dma_stall_cnt;
    logic [15:0] cpu_s0, dma_s0;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [64];

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
        .dma_req_we(dma_req_we), .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
        .dma_resp_valid(dma_resp_valid), .dma_resp_rdata(dma_resp_rdata),
        .dmem_w_en(dmem_w_en), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
`ifdef DMEM_ARB_STALL_CNT_EN
        .cpu_stall_cnt(cpu_stall_cnt), .dma_stall_cnt(dma_stall_cnt),
`endif
        .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    // dcache model: combinational read, write committed on the rising edge
    assign dmem_rdata = mem[dmem_addr];
    always @(posedge clk) if (dmem_w_en) mem[dmem_addr] <= dmem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;

        // ---- reset state ----
        tick(); tick();
        cpu_req_valid = 1'b1; dma_req_valid = 1'b1;
        #1;
        chk("rst_cpu_ready", {31'd0, cpu_req_ready}, 32'd0);
        chk("rst_dma_ready", {31'd0, dma_req_ready}, 32'd0);
        chk("rst_w_en", {31'd0, dmem_w_en}, 32'd0);
        chk("rst_addr", {26'd0, dmem_addr}, 32'd0);
        chk("rst_resp", {30'd0, cpu_resp_valid, dma_resp_valid}, 32'd0);
        cpu_req_valid = 1'b0; dma_req_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // ---- DMA store addr 5, then CPU load addr 5 ----
        dma_req_valid = 1'b1; dma_req_we = 1'b1; dma_req_addr = 6'd5; dma_req_wdata = 32'hDEAD_BEEF;
        #1 chk("t1_dma_ready", {31'd0, dma_req_ready}, 32'd1);
        tick();
        chk("t1_w_en", {31'd0, dmem_w_en}, 32'd1);
        chk("t1_addr", {26'd0, dmem_addr}, 32'd5);
        chk("t1_wdata", dmem_wdata, 32'hDEAD_BEEF);
        dma_req_valid = 1'b0;
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 6'd5;
        #1 chk("t1_cpu_ready", {31'd0, cpu_req_ready}, 32'd1);
        tick();
        cpu_req_valid = 1'b0;
        chk("t1_dma_resp", {31'd0, dma_resp_valid}, 32'd1);
        chk("t1_dma_rdata", dma_resp_rdata, 32'd0);
        chk("t1_cpu_resp_early", {31'd0, cpu_resp_valid}, 32'd0);
        tick();
        chk("t1_cpu_resp", {31'd0, cpu_resp_valid}, 32'd1);
        chk("t1_cpu_rdata", cpu_resp_rdata, 32'hDEAD_BEEF);
        chk("t1_dma_quiet", {31'd0, dma_resp_valid}, 32'd0);
        tick();
        chk("t1_cpu_pulse", {31'd0, cpu_resp_valid}, 32'd0);

        // ---- CPU store addr 3 then load addr 3 back-to-back ----
        cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_addr = 6'd3; cpu_req_wdata = 32'h1234;
        tick();
        cpu_req_we = 1'b0;
        tick();
        cpu_req_valid = 1'b0;
        chk("t2_st_resp", {31'd0, cpu_resp_valid}, 32'd1);
        chk("t2_st_rdata", cpu_resp_rdata, 32'd0);
        tick();
        chk("t2_ld_resp", {31'd0, cpu_resp_valid}, 32'd1);
        chk("t2_ld_rdata", cpu_resp_rdata, 32'h1234);
        tick(); tick();

        // ---- contention: CPU,CPU,CPU,CPU,DMA repeating ----
`ifdef DMEM_ARB_STALL_CNT_EN
        cpu_s0 = cpu_stall_cnt; dma_s0 = dma_stall_cnt;
`endif
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 6'd10;
        dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = 6'd20;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("t3_cpu_ready_%0d", k), {31'd0, cpu_req_ready}, {31'd0, (k % 5) != 4});
            chk($sformatf("t3_dma_ready_%0d", k), {31'd0, dma_req_ready}, {31'd0, (k % 5) == 4});
            tick();
        end
`ifdef DMEM_ARB_STALL_CNT_EN
        chk("t6_cpu_stall", {16'd0, cpu_stall_cnt - cpu_s0}, 32'd2);
        chk("t6_dma_stall", {16'd0, dma_stall_cnt - dma_s0}, 32'd8);
`endif
        cpu_req_valid = 1'b0; dma_req_valid = 1'b0;
        tick(); tick(); tick();

        // ---- idle: no writes, no responses ----
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t4_idle_w_en_%0d", k), {31'd0, dmem_w_en}, 32'd0);
            chk($sformatf("t4_idle_resp_%0d", k), {30'd0, cpu_resp_valid, dma_resp_valid}, 32'd0);
            tick();
        end

        // ---- DMA alone: granted every cycle, one response per cycle ----
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = 6'(11 + i);
                #1 chk($sformatf("t4_dma_ready_%0d", i), {31'd0, dma_req_ready}, 32'd1);
            end else begin
                dma_req_valid = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 4) begin
                chk($sformatf("t4_dma_resp_%0d", i), {31'd0, dma_resp_valid}, 32'd1);
                chk($sformatf("t4_dma_rdata_%0d", i), dma_resp_rdata, 32'hA000_0000 + 32'(10 + i));
            end
        end
        tick();

        // ---- reset while a DMA store to addr 7 sits in ACC ----
        dma_req_valid = 1'b1; dma_req_we = 1'b1; dma_req_addr = 6'd7; dma_req_wdata = 32'h5555_5555;
        tick();
        dma_req_valid = 1'b0;
        chk("t5_store_in_acc", {31'd0, dmem_w_en}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_w_en", {31'd0, dmem_w_en}, 32'd0);
        chk("t5_rst_addr", {26'd0, dmem_addr}, 32'd0);
        chk("t5_rst_wdata", dmem_wdata, 32'd0);
        tick();
        chk("t5_no_dma_resp", {31'd0, dma_resp_valid}, 32'd0);
        reset = 1'b0;
        tick();
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 6'd7;
        tick();
        cpu_req_valid = 1'b0;
        tick();
        chk("t5_ld_resp", {31'd0, cpu_resp_valid}, 32'd1);
        chk("t5_ld_rdata", cpu_resp_rdata, 32'hA000_0007);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
